cache_miss_ctrl: RTL and testbench
==================================

Name: cache_miss_ctrl

Overview:
- Miss sequencer between the 2-way write-back cache and main memory.
- On a cache miss it writes back the dirty victim block, if there is one, then refills the requested block.
- It drives a single block-wide memory port with an en/ready handshake.
- It returns the fill block to the cache with a one-cycle valid pulse, and keeps saturating miss and write-back counters for performance reporting.

Parameters:
- ADDR_W, 10, byte address width.
- BLOCK_W, 128, block width in bits (4 words).
- OFFSET_W, 4, byte-offset bits within a block; forced to zero on mem_addr.
- CNT_W, 16, width of the statistics counters.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- miss_req  input  1  cache reports a miss; sampled only when accepted (see Behaviour).
- miss_dirty  input  1  victim block is dirty and needs write-back.
- victim_addr  input  ADDR_W  victim block address, {tag, index, offset}.
- victim_data  input  BLOCK_W  victim block contents.
- refill_addr  input  ADDR_W  address that missed.
- miss_busy  output  1  controller is occupied; the cache must hold.
- fill_valid  output  1  one-cycle pulse: fill_data is valid.
- fill_data  output  BLOCK_W  refilled block.
- mem_en  output  1  memory request active.
- mem_we  output  1  1 = write, 0 = read.
- mem_addr  output  ADDR_W  block-aligned memory address.
- mem_wdata  output  BLOCK_W  write-back data.
- mem_rdata  input  BLOCK_W  read data; valid when mem_ready=1.
- mem_ready  input  1  memory completes the current request this cycle.
- miss_cnt  output  CNT_W  completed refills; saturates at all-ones.
- wb_cnt  output  CNT_W  completed write-backs; saturates at all-ones.

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous and active-high.
- Reset: every output is 0, the FSM is in IDLE and all capture registers are cleared. mem_en drops immediately on reset assertion, including in the middle of a transfer; the interrupted transfer is abandoned and is not counted.
- FSM states: IDLE, WB, RF, RESP.
- IDLE: miss_busy=0, mem_en=0.
  - When miss_req=1 at a clk edge, capture miss_dirty, victim_addr, victim_data and refill_addr.
  - Next state is WB if dirty, otherwise RF.
- WB: miss_busy=1, mem_en=1, mem_we=1, mem_wdata = captured victim data.
  - mem_addr = {victim_addr[ADDR_W-1:OFFSET_W], OFFSET_W'b0}.
  - Hold all of these until mem_ready=1 at an edge, then wb_cnt++ and go to RF.
- RF: miss_busy=1, mem_en=1, mem_we=0.
  - mem_addr = aligned refill_addr.
  - On mem_ready=1 at an edge, register mem_rdata into fill_data, miss_cnt++ and go to RESP.
- RESP: miss_busy=1, fill_valid=1 for exactly one cycle, then IDLE. fill_data holds its value until the next refill.
- Memory outputs: mem_addr, mem_we and mem_wdata are stable for as long as mem_en=1. mem_ready is ignored while mem_en=0.
- Zero-wait memory (mem_ready=1 in the same cycle as mem_en) is legal.
  - Clean miss accepted at edge 0: RF in cycle 1, RESP in cycle 2.
  - Dirty miss: WB in cycle 1, RF in cycle 2, RESP in cycle 3.
- miss_req is ignored outside IDLE. The cache must hold its request until it sees fill_valid.
- Counters: increment by one per completed transfer, stick at all-ones, and are cleared only by reset.

Optional Feature:
- Macro: CACHE_MISS_CTRL_WB_BUFFER_EN.
- With the macro defined: a one-entry write-back buffer is added and a DRAIN state is added.
  - A dirty miss captures the victim into the buffer and goes straight to RF, then RESP, then DRAIN.
  - In DRAIN: mem_we=1 writing the buffered victim, miss_busy=0, and wb_cnt++ on mem_ready.
  - A miss_req arriving during DRAIN is latched as pending and miss_busy rises on the next cycle. The pending miss starts only after the drain's mem_ready.
  - If a pending refill_addr block equals the buffered victim block, the drain still completes before the refill is issued (no forwarding).
- Without the macro: the WB-then-RF order described in Behaviour applies, and there is no DRAIN state.

Test Plan:
- Clean miss: refill_addr=10'h1A4, mem_ready on the 3rd cycle of RF, mem_rdata=128'hDEAD…0001 -> mem_addr=10'h1A0, mem_we=0, fill_valid pulses once with that data, miss_cnt=1, wb_cnt=0.
- Dirty miss: victim_addr=10'h2F8, victim_data=128'hA5…, refill_addr=10'h054, zero-wait memory -> WB to 10'h2F0 with victim_data, then RF at 10'h050, fill_valid in cycle 3, miss_cnt=1, wb_cnt=1.
- Stall hold: mem_ready low for 10 cycles in WB -> mem_en, mem_we, mem_addr and mem_wdata stay constant; miss_busy=1 throughout; no fill_valid.
- Reset mid-RF: assert reset between edges -> mem_en and miss_busy go to 0 immediately; counters are 0 after release; the next miss completes normally.
- Saturation: force 65536 clean misses -> miss_cnt=16'hFFFF and does not wrap.
- With CACHE_MISS_CTRL_WB_BUFFER_EN, dirty miss followed by a new miss during DRAIN -> order is RF, RESP, DRAIN write; pending miss serviced afterwards; miss_cnt=2, wb_cnt=1.

Source files
------------

// File: rtl/cache_miss_ctrl.sv
// Miss sequencer: writes back a dirty victim, refills the missed block and pulses fill_valid.
// Optional one-entry write-back buffer (refill first, drain after) via CACHE_MISS_CTRL_WB_BUFFER_EN.
module cache_miss_ctrl #(
    parameter int ADDR_W   = 10,
    parameter int BLOCK_W  = 128,
    parameter int OFFSET_W = 4,
    parameter int CNT_W    = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               miss_req,
    input  logic               miss_dirty,
    input  logic [ADDR_W-1:0]  victim_addr,
    input  logic [BLOCK_W-1:0] victim_data,
    input  logic [ADDR_W-1:0]  refill_addr,
    output logic               miss_busy,
    output logic               fill_valid,
    output logic [BLOCK_W-1:0] fill_data,
    output logic               mem_en,
    output logic               mem_we,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [BLOCK_W-1:0] mem_wdata,
    input  logic [BLOCK_W-1:0] mem_rdata,
    input  logic               mem_ready,
    output logic [CNT_W-1:0]   miss_cnt,
    output logic [CNT_W-1:0]   wb_cnt
);

`ifdef CACHE_MISS_CTRL_WB_BUFFER_EN
    typedef enum logic [1:0] {IDLE, RF, RESP, DRAIN} state_t;
`else
    typedef enum logic [1:0] {IDLE, WB, RF, RESP} state_t;
`endif

    state_t               state_q, state_d;
    logic [ADDR_W-1:0]    vaddr_q, vaddr_d;
    logic [BLOCK_W-1:0]   vdata_q, vdata_d;
    logic [ADDR_W-1:0]    raddr_q, raddr_d;
    logic [BLOCK_W-1:0]   fill_q, fill_d;
    logic [CNT_W-1:0]     miss_cnt_q, wb_cnt_q;
    logic                 miss_inc, wb_inc;

`ifdef CACHE_MISS_CTRL_WB_BUFFER_EN
    logic                 dirty_q, dirty_d;
    logic                 pend_q, pend_d;
    logic                 buf_vld_q, buf_vld_d;
    logic [ADDR_W-1:0]    buf_addr_q, buf_addr_d;
    logic [BLOCK_W-1:0]   buf_data_q, buf_data_d;
`endif

    function automatic logic [ADDR_W-1:0] align_blk(input logic [ADDR_W-1:0] a);
        return {a[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
    endfunction

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            vaddr_q    <= '0;
            vdata_q    <= '0;
            raddr_q    <= '0;
            fill_q     <= '0;
`ifdef CACHE_MISS_CTRL_WB_BUFFER_EN
            dirty_q    <= 1'b0;
            pend_q     <= 1'b0;
            buf_vld_q  <= 1'b0;
            buf_addr_q <= '0;
            buf_data_q <= '0;
`endif
        end else begin
            state_q    <= state_d;
            vaddr_q    <= vaddr_d;
            vdata_q    <= vdata_d;
            raddr_q    <= raddr_d;
            fill_q     <= fill_d;
`ifdef CACHE_MISS_CTRL_WB_BUFFER_EN
            dirty_q    <= dirty_d;
            pend_q     <= pend_d;
            buf_vld_q  <= buf_vld_d;
            buf_addr_q <= buf_addr_d;
            buf_data_q <= buf_data_d;
`endif
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            miss_cnt_q <= '0;
            wb_cnt_q   <= '0;
        end else begin
            if (miss_inc) miss_cnt_q <= sat_inc(miss_cnt_q);
            if (wb_inc)   wb_cnt_q   <= sat_inc(wb_cnt_q);
        end
    end

    always_comb begin
        state_d    = state_q;
        vaddr_d    = vaddr_q;
        vdata_d    = vdata_q;
        raddr_d    = raddr_q;
        fill_d     = fill_q;
        miss_inc   = 1'b0;
        wb_inc     = 1'b0;
        miss_busy  = 1'b0;
        fill_valid = 1'b0;
        mem_en     = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
`ifdef CACHE_MISS_CTRL_WB_BUFFER_EN
        dirty_d    = dirty_q;
        pend_d     = pend_q;
        buf_vld_d  = buf_vld_q;
        buf_addr_d = buf_addr_q;
        buf_data_d = buf_data_q;
`endif
        case (state_q)
            IDLE: begin
                if (miss_req) begin
                    raddr_d = refill_addr;
`ifdef CACHE_MISS_CTRL_WB_BUFFER_EN
                    if (miss_dirty) begin
                        buf_addr_d = victim_addr;
                        buf_data_d = victim_data;
                        buf_vld_d  = 1'b1;
                    end
                    state_d = RF;
`else
                    vaddr_d = victim_addr;
                    vdata_d = victim_data;
                    state_d = miss_dirty ? WB : RF;
`endif
                end
            end
`ifndef CACHE_MISS_CTRL_WB_BUFFER_EN
            WB: begin
                miss_busy = 1'b1;
                mem_en    = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = align_blk(vaddr_q);
                mem_wdata = vdata_q;
                if (mem_ready) begin
                    wb_inc  = 1'b1;
                    state_d = RF;
                end
            end
`endif
            RF: begin
                miss_busy = 1'b1;
                mem_en    = 1'b1;
                mem_addr  = align_blk(raddr_q);
                if (mem_ready) begin
                    fill_d   = mem_rdata;
                    miss_inc = 1'b1;
                    state_d  = RESP;
                end
            end
            RESP: begin
                miss_busy  = 1'b1;
                fill_valid = 1'b1;
`ifdef CACHE_MISS_CTRL_WB_BUFFER_EN
                state_d    = buf_vld_q ? DRAIN : IDLE;
`else
                state_d    = IDLE;
`endif
            end
`ifdef CACHE_MISS_CTRL_WB_BUFFER_EN
            DRAIN: begin
                // The cache sees busy only once a new miss has been parked behind the drain.
                miss_busy = pend_q;
                mem_en    = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = align_blk(buf_addr_q);
                mem_wdata = buf_data_q;
                if (miss_req && !pend_q) begin
                    pend_d  = 1'b1;
                    dirty_d = miss_dirty;
                    vaddr_d = victim_addr;
                    vdata_d = victim_data;
                    raddr_d = refill_addr;
                end
                if (mem_ready) begin
                    wb_inc    = 1'b1;
                    buf_vld_d = 1'b0;
                    pend_d    = 1'b0;
                    if (pend_q) begin
                        if (dirty_q) begin
                            buf_addr_d = vaddr_q;
                            buf_data_d = vdata_q;
                            buf_vld_d  = 1'b1;
                        end
                        state_d = RF;
                    end else if (miss_req) begin
                        raddr_d = refill_addr;
                        if (miss_dirty) begin
                            buf_addr_d = victim_addr;
                            buf_data_d = victim_data;
                            buf_vld_d  = 1'b1;
                        end
                        state_d = RF;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    assign fill_data = fill_q;
    assign miss_cnt  = miss_cnt_q;
    assign wb_cnt    = wb_cnt_q;

endmodule

// File: tb/tb_cache_miss_ctrl.sv
// Directed bench for cache_miss_ctrl (default build): a queue-based transfer model checked every
// cycle, plus hand-computed literal expectations at key points of each scenario.
module tb_cache_miss_ctrl;
    localparam int ADDR_W   = 10;
    localparam int BLOCK_W  = 128;
    localparam int OFFSET_W = 4;
    localparam int CNT_W    = 4;   // narrow counters so saturation is reachable quickly

    logic               clk = 1'b0;
    logic               reset;
    logic               miss_req, miss_dirty;
    logic [ADDR_W-1:0]  victim_addr, refill_addr;
    logic [BLOCK_W-1:0] victim_data;
    logic               miss_busy, fill_valid;
    logic [BLOCK_W-1:0] fill_data;
    logic               mem_en, mem_we;
    logic [ADDR_W-1:0]  mem_addr;
    logic [BLOCK_W-1:0] mem_wdata, mem_rdata;
    logic               mem_ready;
    logic [CNT_W-1:0]   miss_cnt, wb_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    cache_miss_ctrl #(
        .ADDR_W(ADDR_W), .BLOCK_W(BLOCK_W), .OFFSET_W(OFFSET_W), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset),
        .miss_req(miss_req), .miss_dirty(miss_dirty),
        .victim_addr(victim_addr), .victim_data(victim_data), .refill_addr(refill_addr),
        .miss_busy(miss_busy), .fill_valid(fill_valid), .fill_data(fill_data),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .miss_cnt(miss_cnt), .wb_cnt(wb_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [BLOCK_W-1:0] act, input logic [BLOCK_W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: a miss expands into an ordered list of memory transfers; after the read completes
    // one response cycle follows. Counters are plain saturating tallies of completed transfers.
    typedef struct {
        bit                 we;
        logic [ADDR_W-1:0]  addr;
        logic [BLOCK_W-1:0] data;
    } op_t;

    op_t                q[$];
    bit                 m_resp;
    logic [BLOCK_W-1:0] m_fill;
    logic [CNT_W-1:0]   m_miss, m_wb;
    localparam logic [ADDR_W-1:0] BLK_MASK = ~(ADDR_W'((1 << OFFSET_W) - 1));

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            q.delete();
            m_resp = 1'b0;
            m_fill = '0;
            m_miss = '0;
            m_wb   = '0;
        end else if (m_resp) begin
            m_resp = 1'b0;
        end else if (q.size() > 0) begin
            if (mem_ready) begin
                if (q[0].we) begin
                    if (m_wb != {CNT_W{1'b1}}) m_wb = m_wb + 1'b1;
                end else begin
                    if (m_miss != {CNT_W{1'b1}}) m_miss = m_miss + 1'b1;
                    m_fill = mem_rdata;
                    m_resp = 1'b1;
                end
                void'(q.pop_front());
            end
        end else if (miss_req) begin
            if (miss_dirty) q.push_back('{1'b1, victim_addr & BLK_MASK, victim_data});
            q.push_back('{1'b0, refill_addr & BLK_MASK, '0});
        end
    end

    always @(negedge clk) begin
        chk("m_busy", miss_busy, (m_resp || q.size() > 0));
        chk("m_fill_valid", fill_valid, m_resp);
        chk("m_mem_en", mem_en, (!m_resp && q.size() > 0));
        if (!m_resp && q.size() > 0) begin
            chk("m_mem_we", mem_we, q[0].we);
            chk("m_mem_addr", mem_addr, q[0].addr);
            if (q[0].we) chk("m_mem_wdata", mem_wdata, q[0].data);
        end
        chk("m_fill_data", fill_data, m_fill);
        chk("m_miss_cnt", miss_cnt, m_miss);
        chk("m_wb_cnt", wb_cnt, m_wb);
    end

    // One memory transfer: hold mem_ready low for 'waits' cycles, then complete it.
    task automatic serve(input int waits, input bit we, input logic [ADDR_W-1:0] ea,
                         input logic [BLOCK_W-1:0] ewd, input logic [BLOCK_W-1:0] rd);
        for (int i = 0; i <= waits; i++) begin
            chk("xfer_en", mem_en, 1'b1);
            chk("xfer_we", mem_we, we);
            chk("xfer_addr", mem_addr, ea);
            if (we) chk("xfer_wdata", mem_wdata, ewd);
            chk("xfer_busy", miss_busy, 1'b1);
            chk("xfer_no_fill", fill_valid, 1'b0);
            mem_ready = (i == waits);
            mem_rdata = (i == waits) ? rd : {$urandom, $urandom, $urandom, $urandom};
            @(posedge clk); #1;
        end
        mem_ready = 1'b0;
        mem_rdata = {$urandom, $urandom, $urandom, $urandom};
    endtask

    task automatic do_miss(input bit d, input logic [ADDR_W-1:0] va, input logic [BLOCK_W-1:0] vd,
                           input logic [ADDR_W-1:0] ra, input logic [BLOCK_W-1:0] rd,
                           input int wwb, input int wrf,
                           input logic [ADDR_W-1:0] e_wb, input logic [ADDR_W-1:0] e_rf);
        miss_dirty  = d;
        victim_addr = va;
        victim_data = vd;
        refill_addr = ra;
        miss_req    = 1'b1;
        @(posedge clk); #1;
        if (d) serve(wwb, 1'b1, e_wb, vd, '0);
        serve(wrf, 1'b0, e_rf, '0, rd);
        chk("resp_fill_valid", fill_valid, 1'b1);
        chk("resp_fill_data", fill_data, rd);
        chk("resp_mem_en", mem_en, 1'b0);
        miss_req   = 1'b0;
        miss_dirty = 1'b0;
        @(posedge clk); #1;
        chk("idle_fill_valid", fill_valid, 1'b0);
        chk("idle_busy", miss_busy, 1'b0);
        chk("resp_data_held", fill_data, rd);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1; miss_req = 1'b0; miss_dirty = 1'b0;
        victim_addr = '0; victim_data = '0; refill_addr = '0;
        mem_ready = 1'b0; mem_rdata = '0;
        repeat (3) @(posedge clk); #1;
        chk("rst_busy", miss_busy, 1'b0);
        chk("rst_mem_en", mem_en, 1'b0);
        chk("rst_fill_valid", fill_valid, 1'b0);
        chk("rst_fill_data", fill_data, '0);
        chk("rst_miss_cnt", miss_cnt, 4'h0);
        chk("rst_wb_cnt", wb_cnt, 4'h0);
        reset = 1'b0;
        @(posedge clk); #1;

        // Clean miss, ready on the third RF cycle.
        do_miss(1'b0, 10'h3C0, 128'h0, 10'h1A4, 128'hDEAD0000_0000_0000_0000_0000_0000_0001,
                0, 2, 10'h000, 10'h1A0);
        chk("clean_miss_cnt", miss_cnt, 4'h1);
        chk("clean_wb_cnt", wb_cnt, 4'h0);
        chk("clean_fill", fill_data, 128'hDEAD0000_0000_0000_0000_0000_0000_0001);

        // Dirty miss, zero-wait memory.
        do_miss(1'b1, 10'h2F8, {16{8'hA5}}, 10'h054, 128'h1234_5678_9ABC_DEF0_0FED_CBA9_8765_4321,
                0, 0, 10'h2F0, 10'h050);
        chk("dirty_miss_cnt", miss_cnt, 4'h2);
        chk("dirty_wb_cnt", wb_cnt, 4'h1);

        // Write-back stalled for 10 cycles.
        do_miss(1'b1, 10'h17C, {4{32'hCAFE_F00D}}, 10'h3FF, {8{16'h5A5A}},
                10, 0, 10'h170, 10'h3F0);
        chk("stall_miss_cnt", miss_cnt, 4'h3);
        chk("stall_wb_cnt", wb_cnt, 4'h2);

        // Reset asserted between edges while in RF.
        miss_dirty = 1'b0; refill_addr = 10'h0A8; miss_req = 1'b1;
        @(posedge clk); #1;
        chk("rf_en_before_rst", mem_en, 1'b1);
        chk("rf_addr_before_rst", mem_addr, 10'h0A0);
        #2 reset = 1'b1;
        #1;
        chk("rst_mid_mem_en", mem_en, 1'b0);
        chk("rst_mid_busy", miss_busy, 1'b0);
        miss_req = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        chk("post_rst_miss_cnt", miss_cnt, 4'h0);
        chk("post_rst_wb_cnt", wb_cnt, 4'h0);
        do_miss(1'b0, 10'h000, 128'h0, 10'h0A8, 128'h0BAD_BEEF, 0, 1, 10'h000, 10'h0A0);
        chk("post_rst_miss", miss_cnt, 4'h1);

        // Saturation: 20 more clean misses on a 4-bit counter.
        for (int i = 0; i < 20; i++) begin
            do_miss(1'b0, 10'h000, 128'h0, ADDR_W'(i * 16 + 5), BLOCK_W'(i + 100),
                    0, 0, 10'h000, ADDR_W'(i * 16));
        end
        chk("sat_miss_cnt", miss_cnt, 4'hF);
        chk("sat_wb_cnt", wb_cnt, 4'h0);

        repeat (2) @(posedge clk); #1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
